// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: owns the register file write port.
// Zero-sweeps all registers after reset, then round-robins two writers.
module regfile_write_arbiter #(
  parameter int NUM_REGS = 64,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_rd_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              init_done,
  output logic              last_grant
);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(NUM_REGS - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_prio;

  logic w_run;
  logic w_both;
  logic w_gnt0;
  logic w_gnt1;

  // A grant offered while rst_n is low would be lost, so gate it.
  assign w_run  = rst_n && (r_state == S_RUN);
  assign w_both = req0_valid && req1_valid;
  assign w_gnt0 = w_run && req0_valid
               && (!req1_valid || !r_prio);
  assign w_gnt1 = w_run && req1_valid
               && (!req0_valid || r_prio);

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  // Sweep/arbitrate FSM; all register-file outputs are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_INIT;
      r_cnt      <= '0;
      r_prio     <= 1'b0;
      rf_write   <= 1'b0;
      rf_rd_addr <= '0;
      rf_data    <= '0;
      init_done  <= 1'b0;
      last_grant <= 1'b0;
    end else begin
      unique case (r_state)
        S_INIT: begin
          rf_write   <= 1'b1;
          rf_rd_addr <= r_cnt;
          rf_data    <= '0;
          r_cnt      <= r_cnt + ADDR_W'(1);
          if (r_cnt == LAST_ADDR) begin
            r_state   <= S_RUN;
            init_done <= 1'b1;
          end
        end
        S_RUN: begin
          unique case (1'b1)
            w_gnt0: begin
              rf_write   <= 1'b1;
              rf_rd_addr <= req0_addr;
              rf_data    <= req0_data;
              last_grant <= 1'b0;
            end
            w_gnt1: begin
              rf_write   <= 1'b1;
              rf_rd_addr <= req1_addr;
              rf_data    <= req1_data;
              last_grant <= 1'b1;
            end
            default: begin
              rf_write <= 1'b0;
            end
          endcase
          if (w_both) begin
            r_prio <= ~r_prio;
          end
        end
        default: begin
          r_state <= S_INIT;
        end
      endcase
    end
  end

endmodule
